// File: rtl/b002_frame_packer.sv
// b002_frame_packer: serializes one 164-bit IRIG-B002 frame ({sync_edge, irig_bits})
// per input beat into a 7-word, 32-bit AXI-stream packet. One active plus one pending
// frame slot; frames arriving while the pending slot is full are counted as drops.
module b002_frame_packer #(
  parameter logic [15:0] MAGIC      = 16'hB002,
  parameter int unsigned SEQ_WIDTH  = 8,
  parameter int unsigned DROP_WIDTH = 8
) (
  input  logic         clk_50MHz,
  input  logic         resetn,
  input  logic [163:0] s_axis_tdata,
  input  logic         s_axis_tvalid,
  output logic         s_axis_tready,
  input  logic         s_axis_tlast,
  output logic [31:0]  m_axis_tdata,
  output logic         m_axis_tvalid,
  input  logic         m_axis_tready,
  output logic         m_axis_tlast
);

  typedef enum logic [0:0] {StIdle, StSend} state_e;

  state_e                  state_q, state_d;
  logic [2:0]              idx_q, idx_d;
  logic [163:0]            pend_data_q, pend_data_d;
  logic                    pend_valid_q, pend_valid_d;
  logic [163:0]            act_data_q, act_data_d;
  logic [SEQ_WIDTH-1:0]    seq_q, seq_d, seq_inc;
  logic [DROP_WIDTH-1:0]   drops_q, drops_d;
  logic [31:0]             tdata_q, tdata_d;
  logic                    tvalid_q, tvalid_d;
  logic                    tlast_q, tlast_d;
  logic                    accept, drop, hs, w0_hs, load;
  logic                    unused_tlast;

  // Every input beat carries a whole frame, so the input tlast carries no information.
  assign unused_tlast = s_axis_tlast;

  assign s_axis_tready = ~pend_valid_q;
  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = tlast_q;

  assign accept  = s_axis_tvalid & ~pend_valid_q;
  assign drop    = s_axis_tvalid & pend_valid_q;
  assign hs      = tvalid_q & m_axis_tready;
  assign w0_hs   = hs & (state_q == StSend) & (idx_q == 3'd0);
  assign seq_inc = seq_q + SEQ_WIDTH'(1);

  // Payload words W1..W6 of the active frame; W0 (header) is built separately.
  function automatic logic [31:0] frame_word(input logic [163:0] f, input logic [2:0] idx);
    logic [31:0] w;
    case (idx)
      3'd1:    w = f[131:100];
      3'd2:    w = f[163:132];
      3'd3:    w = f[31:0];
      3'd4:    w = f[63:32];
      3'd5:    w = f[95:64];
      3'd6:    w = {28'h0, f[99:96]};
      default: w = 32'h0;
    endcase
    return w;
  endfunction

  // Packet FSM: header load, word stepping on handshake, back-to-back reload.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    act_data_d = act_data_q;
    seq_d      = seq_q;
    tdata_d    = tdata_q;
    tvalid_d   = tvalid_q;
    tlast_d    = tlast_q;
    load       = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (pend_valid_q) begin
          load       = 1'b1;
          act_data_d = pend_data_q;
          tdata_d    = {MAGIC, seq_q, drops_q};
          tvalid_d   = 1'b1;
          tlast_d    = 1'b0;
          idx_d      = 3'd0;
          state_d    = StSend;
        end
      end
      StSend: begin
        if (hs) begin
          if (idx_q == 3'd6) begin
            seq_d = seq_inc;
            if (pend_valid_q) begin
              // Next header goes out on the following cycle with no bubble.
              load       = 1'b1;
              act_data_d = pend_data_q;
              tdata_d    = {MAGIC, seq_inc, drops_q};
              tlast_d    = 1'b0;
              idx_d      = 3'd0;
            end else begin
              tdata_d  = 32'h0;
              tvalid_d = 1'b0;
              tlast_d  = 1'b0;
              idx_d    = 3'd0;
              state_d  = StIdle;
            end
          end else begin
            idx_d   = idx_q + 3'd1;
            tdata_d = frame_word(act_data_q, idx_q + 3'd1);
            tlast_d = (idx_q == 3'd5);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Pending slot and saturating drop counter; a drop coinciding with the header
  // handshake restarts the count at one.
  always_comb begin
    pend_valid_d = pend_valid_q;
    pend_data_d  = pend_data_q;
    drops_d      = drops_q;
    if (accept) begin
      pend_valid_d = 1'b1;
      pend_data_d  = s_axis_tdata;
    end else if (load) begin
      pend_valid_d = 1'b0;
    end
    if (w0_hs) begin
      drops_d = drop ? DROP_WIDTH'(1) : '0;
    end else if (drop && (drops_q != {DROP_WIDTH{1'b1}})) begin
      drops_d = drops_q + DROP_WIDTH'(1);
    end
  end

  // State registers; reset discards both frames and any partial packet.
  always_ff @(posedge clk_50MHz or negedge resetn) begin
    if (!resetn) begin
      state_q      <= StIdle;
      idx_q        <= 3'd0;
      pend_valid_q <= 1'b0;
      pend_data_q  <= '0;
      act_data_q   <= '0;
      seq_q        <= '0;
      drops_q      <= '0;
      tdata_q      <= 32'h0;
      tvalid_q     <= 1'b0;
      tlast_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      pend_valid_q <= pend_valid_d;
      pend_data_q  <= pend_data_d;
      act_data_q   <= act_data_d;
      seq_q        <= seq_d;
      drops_q      <= drops_d;
      tdata_q      <= tdata_d;
      tvalid_q     <= tvalid_d;
      tlast_q      <= tlast_d;
    end
  end

endmodule

// File: tb/tb_b002_frame_packer.sv
// Scoreboard bench for b002_frame_packer: stimulus pushes expected packet words,
// a negedge monitor pops and compares on every output handshake and checks stall hold.
module tb_b002_frame_packer;

  logic         clk;
  logic         resetn;
  logic [163:0] s_axis_tdata;
  logic         s_axis_tvalid;
  logic         s_axis_tready;
  logic         s_axis_tlast;
  logic [31:0]  m_axis_tdata;
  logic         m_axis_tvalid;
  logic         m_axis_tready;
  logic         m_axis_tlast;

  typedef struct {
    logic [31:0] data;
    logic        last;
  } exp_t;

  exp_t exp_q[$];
  int   vectors;
  int   miscompares;
  bit   done4;

  b002_frame_packer dut (
    .clk_50MHz     (clk),
    .resetn        (resetn),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tlast  (s_axis_tlast),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] d, input logic l);
    exp_t e;
    e.data = d;
    e.last = l;
    exp_q.push_back(e);
  endtask

  task automatic push_pkt(input logic [31:0] hdr, input logic [163:0] f);
    logic [63:0] se;
    logic [99:0] ir;
    se = f[163:100];
    ir = f[99:0];
    push(hdr, 1'b0);
    push(se[31:0], 1'b0);
    push(se[63:32], 1'b0);
    push(ir[31:0], 1'b0);
    push(ir[63:32], 1'b0);
    push(ir[95:64], 1'b0);
    push({28'h0, ir[99:96]}, 1'b1);
  endtask

  function automatic logic [163:0] mk_frame(input int k);
    logic [31:0] v;
    v = 32'(k);
    return {32'hA5A5_0000 ^ v, 32'h1111_0000 + v, 4'(k), 32'h2222_0000 + v,
            32'h3333_0000 ^ v, 32'hC0DE_0000 + v};
  endfunction

  task automatic send(input logic [163:0] f);
    s_axis_tdata  = f;
    s_axis_tvalid = 1'b1;
    s_axis_tlast  = 1'b1;
    tick();
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    tick();
    tick();
    exp_q.delete();
    resetn = 1'b1;
    tick();
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || m_axis_tvalid) && n < budget) begin
      tick();
      n++;
    end
    vectors++;
    if (exp_q.size() != 0 || m_axis_tvalid) begin
      miscompares++;
      $display("FAIL drain: %0d beats still outstanding after %0d cycles, required 0",
               exp_q.size(), budget);
      exp_q.delete();
    end
  endtask

  // Monitor: score every handshake and check that stalled beats hold still.
  initial begin
    logic        stall;
    logic [31:0] pdata;
    logic        plast;
    exp_t        e;
    stall = 1'b0;
    pdata = 32'h0;
    plast = 1'b0;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        stall = 1'b0;
      end else begin
        if (stall) begin
          check("hold_valid", {31'b0, m_axis_tvalid}, 32'd1);
          check("hold_data", m_axis_tdata, pdata);
          check("hold_last", {31'b0, m_axis_tlast}, {31'b0, plast});
        end
        if (m_axis_tvalid && m_axis_tready) begin
          if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_beat: got %h, required no beat", m_axis_tdata);
          end else begin
            e = exp_q.pop_front();
            check("beat_data", m_axis_tdata, e.data);
            check("beat_last", {31'b0, m_axis_tlast}, {31'b0, e.last});
          end
        end
        stall = m_axis_tvalid && !m_axis_tready;
        pdata = m_axis_tdata;
        plast = m_axis_tlast;
      end
    end
  end

  initial begin
    logic [163:0] f;
    logic [163:0] fb;
    logic [99:0]  ir;
    int           nval;
    int           nrise;
    logic         prev;
    int           n;

    vectors       = 0;
    miscompares   = 0;
    done4         = 1'b0;
    resetn        = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    m_axis_tready = 1'b1;
    repeat (3) tick();

    // Reset state, held in reset and just after release.
    check("rst_tvalid", {31'b0, m_axis_tvalid}, 32'd0);
    check("rst_tlast", {31'b0, m_axis_tlast}, 32'd0);
    check("rst_tdata", m_axis_tdata, 32'h0);
    check("rst_tready", {31'b0, s_axis_tready}, 32'd1);
    resetn = 1'b1;
    tick();
    check("rst_rel_tvalid", {31'b0, m_axis_tvalid}, 32'd0);

    // 1: single known frame, hand-computed words, header latency.
    push(32'hB002_0000, 1'b0);
    push(32'h89AB_CDEF, 1'b0);
    push(32'h0123_4567, 1'b0);
    push(32'hDEAD_BEEF, 1'b0);
    push(32'h8000_0000, 1'b0);
    push(32'h0000_0001, 1'b0);
    push(32'h0000_000F, 1'b1);
    send({64'h0123_4567_89AB_CDEF, 100'hF_0000_0001_8000_0000_DEAD_BEEF});
    check("t1_not_yet_valid", {31'b0, m_axis_tvalid}, 32'd0);
    tick();
    check("t1_w0_valid", {31'b0, m_axis_tvalid}, 32'd1);
    check("t1_w0_data", m_axis_tdata, 32'hB002_0000);
    drain(50);

    // 2: two frames three cycles apart -> 14 consecutive valid cycles.
    do_reset();
    f  = mk_frame(1);
    fb = mk_frame(2);
    push_pkt(32'hB002_0000, f);
    push_pkt(32'hB002_0100, fb);
    send(f);
    nval  = 0;
    nrise = 0;
    prev  = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (c == 2) begin
        s_axis_tdata  = fb;
        s_axis_tvalid = 1'b1;
      end else begin
        s_axis_tvalid = 1'b0;
      end
      tick();
      if (m_axis_tvalid) nval++;
      if (m_axis_tvalid && !prev) nrise++;
      prev = m_axis_tvalid;
    end
    check("t2_valid_cycles", 32'(nval), 32'd14);
    check("t2_valid_bursts", 32'(nrise), 32'd1);
    drain(50);

    // 3: stall with three frames, third dropped; drop after header handshake is reported.
    do_reset();
    m_axis_tready = 1'b0;
    push_pkt(32'hB002_0000, mk_frame(11));
    push_pkt(32'hB002_0100, mk_frame(12));
    send(mk_frame(11));
    tick();
    check("t3_tready_free", {31'b0, s_axis_tready}, 32'd1);
    send(mk_frame(12));
    tick();
    check("t3_tready_full", {31'b0, s_axis_tready}, 32'd0);
    send(mk_frame(13));
    repeat (15) tick();
    m_axis_tready = 1'b1;
    n = 0;
    while (exp_q.size() > 6 && n < 60) begin
      tick();
      n++;
    end
    check("t3_second_hdr_taken", 32'(exp_q.size()), 32'd6);
    push_pkt(32'hB002_0201, mk_frame(14));
    send(mk_frame(14));
    send(mk_frame(15));
    drain(100);

    // 4: random back-pressure; monitor checks hold and order.
    do_reset();
    fork
      begin
        while (!done4) begin
          m_axis_tready = 1'($urandom_range(0, 1));
          tick();
        end
      end
      begin
        for (int k = 0; k < 4; k++) begin
          push_pkt({16'hB002, 8'(k), 8'h00}, mk_frame(20 + k));
          send(mk_frame(20 + k));
          drain(400);
        end
        done4 = 1'b1;
      end
    join
    m_axis_tready = 1'b1;
    tick();

    // 5: drops saturate while stalled after a header handshake, then clear.
    do_reset();
    f = mk_frame(40);
    push_pkt(32'hB002_0000, f);
    send(f);
    tick();
    tick();
    m_axis_tready = 1'b0;
    push_pkt(32'hB002_01FF, mk_frame(41));
    for (int k = 0; k < 300; k++) send(mk_frame(41 + k));
    check("t5_tready_full", {31'b0, s_axis_tready}, 32'd0);
    m_axis_tready = 1'b1;
    drain(100);
    push_pkt(32'hB002_0200, mk_frame(400));
    send(mk_frame(400));
    drain(50);

    // 5b: sequence counter wraps 255 -> 0.
    do_reset();
    for (int k = 0; k < 257; k++) begin
      push_pkt({16'hB002, 8'(k), 8'h00}, mk_frame(500 + k));
      send(mk_frame(500 + k));
      drain(50);
    end

    // 6: reset in the middle of a stalled W3.
    do_reset();
    f  = mk_frame(60);
    ir = f[99:0];
    push_pkt(32'hB002_0000, f);
    send(f);
    repeat (4) tick();
    m_axis_tready = 1'b0;
    check("t6_w3_presented", m_axis_tdata, ir[31:0]);
    repeat (3) tick();
    #2;
    resetn = 1'b0;
    #1;
    check("t6_async_tvalid", {31'b0, m_axis_tvalid}, 32'd0);
    check("t6_async_tlast", {31'b0, m_axis_tlast}, 32'd0);
    check("t6_async_tdata", m_axis_tdata, 32'h0);
    exp_q.delete();
    tick();
    tick();
    resetn = 1'b1;
    m_axis_tready = 1'b1;
    tick();
    check("t6_tready_after", {31'b0, s_axis_tready}, 32'd1);
    push_pkt(32'hB002_0000, mk_frame(61));
    send(mk_frame(61));
    drain(50);

    repeat (5) tick();
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
